// File: rtl/ad4003_frame_streamer.sv
// Snapshots each AD4003 frame when the deserializer shift enable falls and streams it
// one channel per AXI4-Stream word. Define AD4003_FRAME_HEADER_EN for a per-packet header word.
module ad4003_frame_streamer #(
  parameter int NCH      = 48,
  parameter int SAMPLE_W = 18,
  parameter int DECIM_W  = 8
) (
  input  logic                    adc_read_clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic [DECIM_W-1:0]      decim,
  input  logic                    frame_shift_en,
  input  logic [NCH*SAMPLE_W-1:0] adc_data,
  output logic [31:0]             m_tdata,
  output logic                    m_tvalid,
  input  logic                    m_tready,
  output logic                    m_tlast,
  output logic                    busy,
  output logic [15:0]             frame_cnt,
  output logic [15:0]             overflow_cnt
);
  localparam logic [7:0] LAST_IDX = 8'(NCH - 1);
  localparam int         OFS_W    = $clog2(NCH * SAMPLE_W);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t                  state_q, state_d;
  logic                    en_d_q, en_d_d;
  logic [7:0]              idx_q, idx_d;
  logic [DECIM_W-1:0]      dcnt_q, dcnt_d;
  logic [15:0]             frame_cnt_q, frame_cnt_d;
  logic [15:0]             overflow_cnt_q, overflow_cnt_d;
  logic [NCH*SAMPLE_W-1:0] shadow_q, shadow_d;
  logic [31:0]             tdata_q, tdata_d;
  logic                    tvalid_q, tvalid_d;
  logic                    tlast_q, tlast_d;
  logic                    frame_end, handshake, open_slot;
  logic [7:0]              adv_idx;

  function automatic logic signed [SAMPLE_W-1:0] chan(input logic [NCH*SAMPLE_W-1:0] vec,
                                                      input logic [7:0] idx);
    logic [OFS_W-1:0] ofs;
    ofs = OFS_W'(idx) * OFS_W'(SAMPLE_W);
    return vec[ofs +: SAMPLE_W];
  endfunction

  function automatic logic [31:0] pack_word(input logic [7:0] idx,
                                            input logic signed [SAMPLE_W-1:0] s);
    logic signed [23:0] s_ext;
    s_ext = {{(24-SAMPLE_W){s[SAMPLE_W-1]}}, s};
    return {idx, s_ext};
  endfunction

  assign frame_end = en_d_q & ~frame_shift_en;
  assign handshake = tvalid_q & m_tready;
  // The cycle that retires the last word can also take the next frame.
  assign open_slot = (state_q == IDLE) | (handshake & tlast_q);

`ifdef AD4003_FRAME_HEADER_EN
  logic hdr_q, hdr_d;
  assign adv_idx = hdr_q ? 8'd0 : idx_q + 8'd1;
`else
  assign adv_idx = idx_q + 8'd1;
`endif

  always_comb begin
    state_d        = state_q;
    en_d_d         = frame_shift_en;
    idx_d          = idx_q;
    dcnt_d         = dcnt_q;
    frame_cnt_d    = frame_cnt_q;
    overflow_cnt_d = overflow_cnt_q;
    shadow_d       = shadow_q;
    tdata_d        = tdata_q;
    tvalid_d       = tvalid_q;
    tlast_d        = tlast_q;
`ifdef AD4003_FRAME_HEADER_EN
    hdr_d          = hdr_q;
`endif
    if (handshake) begin
      if (tlast_q) begin
        state_d  = IDLE;
        tvalid_d = 1'b0;
        tlast_d  = 1'b0;
      end else begin
        idx_d   = adv_idx;
        tdata_d = pack_word(adv_idx, chan(shadow_q, adv_idx));
        tlast_d = (adv_idx == LAST_IDX);
`ifdef AD4003_FRAME_HEADER_EN
        hdr_d   = 1'b0;
`endif
      end
    end
    if (frame_end) begin
      if (open_slot) begin
        if (enable) begin
          if (dcnt_q == '0) begin
            shadow_d    = adc_data;
            idx_d       = 8'd0;
            dcnt_d      = decim;
            frame_cnt_d = frame_cnt_q + 16'd1;
            state_d     = STREAM;
            tvalid_d    = 1'b1;
`ifdef AD4003_FRAME_HEADER_EN
            hdr_d       = 1'b1;
            tdata_d     = {8'hA5, 8'(NCH), frame_cnt_q + 16'd1};
            tlast_d     = 1'b0;
`else
            tdata_d     = pack_word(8'd0, chan(adc_data, 8'd0));
            tlast_d     = (LAST_IDX == 8'd0);
`endif
          end else begin
            dcnt_d = dcnt_q - DECIM_W'(1);
          end
        end
      end else if (overflow_cnt_q != 16'hFFFF) begin
        overflow_cnt_d = overflow_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge adc_read_clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      en_d_q         <= 1'b0;
      idx_q          <= 8'd0;
      dcnt_q         <= '0;
      frame_cnt_q    <= 16'd0;
      overflow_cnt_q <= 16'd0;
      tdata_q        <= 32'd0;
      tvalid_q       <= 1'b0;
      tlast_q        <= 1'b0;
`ifdef AD4003_FRAME_HEADER_EN
      hdr_q          <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      en_d_q         <= en_d_d;
      idx_q          <= idx_d;
      dcnt_q         <= dcnt_d;
      frame_cnt_q    <= frame_cnt_d;
      overflow_cnt_q <= overflow_cnt_d;
      tdata_q        <= tdata_d;
      tvalid_q       <= tvalid_d;
      tlast_q        <= tlast_d;
`ifdef AD4003_FRAME_HEADER_EN
      hdr_q          <= hdr_d;
`endif
    end
  end

  // Sample snapshot is pure data and needs no reset.
  always_ff @(posedge adc_read_clk) begin
    shadow_q <= shadow_d;
  end

  assign m_tdata      = tdata_q;
  assign m_tvalid     = tvalid_q;
  assign m_tlast      = tlast_q;
  assign busy         = (state_q == STREAM);
  assign frame_cnt    = frame_cnt_q;
  assign overflow_cnt = overflow_cnt_q;

endmodule

// File: doc/ad4003_frame_streamer.md
Name: ad4003_frame_streamer

Overview:
- Readout scheduler for the 48-channel AD4003 deserializer output (24 ADC pairs, 18 bits each).
- Detects the end of each conversion frame from the deserializer's synchronized shift-enable and snapshots the 864-bit sample vector into a shadow register.
- Applies frame decimation, then streams the frame one channel per word over an AXI4-Stream master with backpressure.
- Sits in the adc_read_clk domain, between the deserializer and the DMA/packetizer; counts accepted and dropped frames.

Parameters:
- NCH, 48, number of channels per frame.
- SAMPLE_W, 18, bits per sample.
- DECIM_W, 8, width of the decimation ratio input.

Ports:
- adc_read_clk  in  1  clock; same clock the deserializer shifts on.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  accept new frames when high.
- decim  in  DECIM_W  keep 1 of every decim+1 frames.
- frame_shift_en  in  1  deserializer synchronized reader enable; high while shifting.
- adc_data  in  NCH*SAMPLE_W  sample vector; channel k = adc_data[SAMPLE_W*k+SAMPLE_W-1 -: SAMPLE_W].
- m_tdata  out  32  stream word.
- m_tvalid  out  1  stream valid.
- m_tready  in  1  stream ready.
- m_tlast  out  1  last word of frame packet.
- busy  out  1  high while in STREAM.
- frame_cnt  out  16  accepted frames, wrapping.
- overflow_cnt  out  16  frames dropped while streaming, saturating at 16'hFFFF.

Behaviour:
- Reset (async, rst=1): state IDLE; m_tvalid, m_tlast, busy = 0; m_tdata, frame_cnt, overflow_cnt, decimation counter, channel index, en_d = 0. All outputs drop in the same instant, even mid-packet.
- Edge detect:
  - en_d <= frame_shift_en every clock.
  - frame_end = en_d & ~frame_shift_en (combinational).
  - adc_data is stable while frame_shift_en is low; it is sampled only on frame_end.
- States: IDLE, STREAM.
- IDLE, frame_end and enable=1:
  - Decimation counter 0: load shadow <= adc_data, idx <= 0, dcnt <= decim, frame_cnt++, go STREAM.
  - Otherwise: dcnt--, stay IDLE.
- IDLE, frame_end and enable=0: ignored. No counter changes.
- STREAM:
  - m_tvalid = 1.
  - m_tdata = {idx[7:0], {(24-SAMPLE_W){s[SAMPLE_W-1]}}, s}, where s = shadow channel idx (sign-extended to 24 bits).
  - m_tlast = (idx == NCH-1).
  - On handshake (m_tvalid & m_tready): idx++.
  - On handshake with tlast: go IDLE.
  - m_tvalid/m_tdata are registered outputs and hold stable while m_tready=0.
- frame_end during STREAM (not coinciding with the last handshake): frame dropped; overflow_cnt++ (saturating); dcnt unchanged; shadow untouched.
- Last handshake and frame_end in the same cycle, enable=1: treated as IDLE acceptance. Decimation rule applies; if accepted, shadow reloads, idx=0, stay STREAM; no overflow counted.
- Latency: m_tvalid rises on the clock edge after the edge where frame_end was sampled true. One word per cycle under continuous m_tready.
- enable deasserted mid-packet: current packet completes; no truncated packets.
- decim changes take effect at the next dcnt reload.
- busy = (state == STREAM).

Optional Feature:
- Macro: AD4003_FRAME_HEADER_EN.
- Defined: each packet is prefixed with a header word {8'hA5, NCH[7:0], frame_cnt} (post-increment frame_cnt, first frame = 1). Packet is NCH+1 words; header never carries tlast. The header index state precedes idx=0.
- Not defined: packet is exactly NCH sample words, with no header logic.

Test Plan:
- Reset, enable=1, decim=0, one frame with channel k = k → 48 words 0x00000000, 0x01000001, …, 0x2F00002F (tlast only on the last word); frame_cnt=1.
- Channel 5 = 18'h20000, channel 6 = 18'h1FFFF → words 0x05FE0000 and 0x0601FFFF.
- m_tready low for 10 cycles at word 20, plus a second frame_end during the packet → tdata/tvalid held constant; 48 words total; overflow_cnt=1; no second packet.
- decim=2, 6 frames with idle gaps → packets for frames 1 and 4 only; frame_cnt=2.
- frame_end coincides with the word-47 handshake → next packet's word 0 is valid on the following cycle; overflow_cnt=0; frame_cnt=2.
- rst pulsed at word 10 → m_tvalid=0 immediately; counters 0; next frame streams from word 0 normally.
